// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU/APU register map and sprite DMA state type
// Contents:
//   dma_state_t     : sprite DMA sequencer states
//   PPU_REG_OAMDATA : PPU OAM data port address
//   APU_REG_OAMDMA  : CPU address whose write launches a sprite DMA
package ppu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WRITE
   } dma_state_t;

   localparam logic [15:0] PPU_REG_OAMDATA = 16'h2004;
   localparam logic [15:0] APU_REG_OAMDMA  = 16'h4014;

endpackage

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - CPU-side sprite DMA initiator (page -> OAMDATA copy)
// Ports:
//   clk          : CPU cycle clock, one edge per CPU cycle
//   reset        : asynchronous, active-high
//   cpu_addr_in  : CPU bus address
//   cpu_data_in  : CPU write data (source page on a trigger write)
//   WE           : CPU write strobe
//   mem_data_in  : bus read data, valid in the DMA read cycle
//   dma_active   : CPU halt; DMA owns the bus while high
//   dma_addr_out : bus address driven by the DMA
//   dma_data_out : bus write data driven by the DMA
//   dma_we       : DMA write strobe
//   dma_re       : DMA read strobe
module oam_dma
   import ppu_pkg::*;
#(
   parameter logic [15:0] DMA_TRIG_ADDR = APU_REG_OAMDMA,
   parameter logic [15:0] OAM_DATA_ADDR = PPU_REG_OAMDATA,
   parameter int          XFER_LEN      = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr_in,
   input  logic [7:0]  cpu_data_in,
   input  logic        WE,
   input  logic [7:0]  mem_data_in,
   output logic        dma_active,
   output logic [15:0] dma_addr_out,
   output logic [7:0]  dma_data_out,
   output logic        dma_we,
   output logic        dma_re
);

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   dma_state_t state;
   logic [7:0] page;
   logic [7:0] idx;
   logic [7:0] latch;
   // 0 = get (even) cycle, 1 = put (odd) cycle; free-running from reset.
   logic       parity;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         page   <= 8'h00;
         idx    <= 8'h00;
         latch  <= 8'h00;
         parity <= 1'b0;
      end else begin
         parity <= ~parity;
         case (state)
            IDLE: begin
               if (WE && (cpu_addr_in == DMA_TRIG_ADDR)) begin
                  page  <= cpu_data_in;
                  idx   <= 8'h00;
                  state <= HALT;
               end
            end
            // Reads must land on get cycles; burn one extra cycle when
            // the cycle after HALT would be a put cycle.
            HALT:    state <= parity ? READ : ALIGN;
            ALIGN:   state <= READ;
            READ: begin
               latch <= mem_data_in;
               state <= WRITE;
            end
            WRITE: begin
               idx   <= idx + 8'd1;
               state <= (idx == LAST_IDX) ? IDLE : READ;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Pure decode of registered state: no path from the cpu_* inputs.
   always_comb begin
      dma_active   = 1'b0;
      dma_addr_out = 16'h0000;
      dma_data_out = 8'h00;
      dma_we       = 1'b0;
      dma_re       = 1'b0;
      case (state)
         HALT, ALIGN: dma_active = 1'b1;
         READ: begin
            dma_active   = 1'b1;
            dma_re       = 1'b1;
            dma_addr_out = {page, idx};
         end
         WRITE: begin
            dma_active   = 1'b1;
            dma_we       = 1'b1;
            dma_addr_out = OAM_DATA_ADDR;
            dma_data_out = latch;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - scoreboard bench for oam_dma
module tb_oam_dma;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] cpu_addr_in = 16'h0000;
   logic [7:0]  cpu_data_in = 8'h00;
   logic        WE = 1'b0;
   logic [7:0]  mem_data_in;
   logic        dma_active;
   logic [15:0] dma_addr_out;
   logic [7:0]  dma_data_out;
   logic        dma_we;
   logic        dma_re;

   oam_dma dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_addr_in  (cpu_addr_in),
      .cpu_data_in  (cpu_data_in),
      .WE           (WE),
      .mem_data_in  (mem_data_in),
      .dma_active   (dma_active),
      .dma_addr_out (dma_addr_out),
      .dma_data_out (dma_data_out),
      .dma_we       (dma_we),
      .dma_re       (dma_re)
   );

   always #5 clk = ~clk;

   // Source memory: byte at offset a is a ^ 8'h5A.
   assign mem_data_in = dma_addr_out[7:0] ^ 8'h5A;

   typedef struct {
      int          cyc;
      logic [15:0] addr;
      logic [7:0]  data;
      logic        wr;
   } op_t;

   op_t exp_q[$];
   int  len_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  edge_cnt;
   int  model_last = -1;
   int  run_len = 0;
   op_t op;

   // Cycle index since reset release; the design's parity is edge_cnt % 2.
   always @(posedge clk or posedge reset) begin
      if (reset) edge_cnt <= 0;
      else       edge_cnt <= edge_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a trigger accepted in cycle n puts HALT at n+1,
   // reads on the following even cycles, one byte per two cycles.
   task automatic model_bus(input logic [15:0] a, input logic [7:0] d, input logic w);
      int halt;
      int first_rd;
      if (w && a == 16'h4014 && edge_cnt > model_last) begin
         halt     = edge_cnt + 1;
         first_rd = (halt % 2 == 1) ? halt + 1 : halt + 2;
         for (int i = 0; i < 256; i++) begin
            exp_q.push_back('{first_rd + 2 * i, {d, 8'(i)}, 8'h00, 1'b0});
            exp_q.push_back('{first_rd + 2 * i + 1, 16'h2004, 8'(i) ^ 8'h5A, 1'b1});
         end
         model_last = first_rd + 511;
         len_q.push_back(model_last - halt + 1);
      end
   endtask

   task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic w);
      cpu_addr_in = a;
      cpu_data_in = d;
      WE          = w;
      model_bus(a, d, w);
      @(posedge clk);
      #1;
   endtask

   task automatic noise(input int n);
      logic [15:0] a;
      repeat (n) begin
         a = 16'($urandom);
         if (a == 16'h4014) a = 16'h4015;
         bus(a, 8'($urandom), 1'($urandom));
      end
   endtask

   task automatic trig_parity(input logic [7:0] pg, input bit halt_odd);
      while ((((edge_cnt + 1) % 2) == 1) != halt_odd) noise(1);
      bus(16'h4014, pg, 1'b1);
   endtask

   task automatic wait_done();
      int k = 0;
      while ((dma_active || edge_cnt <= model_last) && k < 1500) begin
         noise(1);
         k++;
      end
      check("wait_done_timeout", 32'(k < 1500), 32'd1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_active"}, 32'(dma_active), 32'd0);
      check({tag, "_we"}, 32'(dma_we), 32'd0);
      check({tag, "_re"}, 32'(dma_re), 32'd0);
      check({tag, "_addr"}, 32'(dma_addr_out), 32'd0);
      check({tag, "_data"}, 32'(dma_data_out), 32'd0);
   endtask

   // Monitor: pops the scoreboard on every strobe cycle.
   always @(negedge clk) begin
      if (reset) begin
         run_len = 0;
      end else begin
         if (dma_re || dma_we) begin
            check("strobe_with_active", 32'(dma_active), 32'd1);
            if (exp_q.size() == 0) begin
               check("spurious_strobe", 32'd1, 32'd0);
            end else begin
               op = exp_q.pop_front();
               check("op_cycle", 32'(edge_cnt), 32'(op.cyc));
               check("op_addr", 32'(dma_addr_out), 32'(op.addr));
               check("op_we", 32'(dma_we), 32'(op.wr));
               check("op_re", 32'(dma_re), 32'(!op.wr));
               if (op.wr) check("op_data", 32'(dma_data_out), 32'(op.data));
            end
         end else begin
            check("idle_addr_zero", 32'(dma_addr_out), 32'd0);
         end
         if (!dma_we) check("data_zero", 32'(dma_data_out), 32'd0);
         if (dma_active) begin
            run_len++;
         end else if (run_len > 0) begin
            if (len_q.size() == 0) check("spurious_active", 32'(run_len), 32'd0);
            else                   check("active_len", 32'(run_len), 32'(len_q.pop_front()));
            run_len = 0;
         end
      end
   end

   initial begin
      #1_000_000;
      n_bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1;
      reset = 1'b1;
      #1;
      check_outputs_zero("reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      noise(3);

      // HALT on an odd cycle: 513-cycle stall, page 02.
      trig_parity(8'h02, 1'b1);
      wait_done();
      // HALT on an even cycle: ALIGN inserted, 514 cycles.
      trig_parity(8'h02, 1'b0);
      wait_done();

      // Non-trigger accesses.
      bus(16'h4015, 8'h09, 1'b1);
      bus(16'h4014, 8'h09, 1'b0);
      check("nontrig_active", 32'(dma_active), 32'd0);
      noise(4);
      check("nontrig_active_late", 32'(dma_active), 32'd0);

      // Retrigger around byte 40 is ignored.
      trig_parity(8'h02, 1'($urandom));
      noise(82);
      check("retrig_busy", 32'(dma_active), 32'd1);
      bus(16'h4014, 8'h07, 1'b1);
      wait_done();

      // Async reset around byte 100, between edges.
      trig_parity(8'($urandom), 1'($urandom));
      noise(200);
      #2;
      reset = 1'b1;
      #1;
      check_outputs_zero("midreset");
      exp_q.delete();
      len_q.delete();
      model_last = -1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      noise(2);
      trig_parity(8'h03, 1'($urandom));
      wait_done();

      // Back-to-back: trigger in the first idle cycle.
      bus(16'h4014, 8'($urandom), 1'b1);
      check("b2b_halt", 32'(dma_active), 32'd1);
      wait_done();

      repeat (3) begin
         noise(int'($urandom_range(0, 5)));
         trig_parity(8'($urandom), 1'($urandom));
         wait_done();
      end

      noise(3);
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      check("len_q_empty", 32'(len_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
